// File: rtl/spike_rate_decoder.sv
// Spike-train decoder: counts spike rising edges over a 2^WINDOW_LOG2 enabled-cycle window,
// tracks the latest interspike interval and presents both through a registered valid/ready port.
module spike_rate_decoder #(
  parameter int unsigned WINDOW_LOG2 = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spike,
  input  logic       enable,
  input  logic       out_ready,
  output logic [7:0] rate,
  output logic [7:0] isi,
  output logic       out_valid,
  output logic       overrun
);

  logic                   spike_d;
  logic [WINDOW_LOG2-1:0] win_cnt;
  logic [7:0]             spk_cnt;
  logic [7:0]             isi_cnt;
  logic [7:0]             last_isi;
  logic                   seen_first;

  logic                   spike_event;
  logic                   terminal;
  logic                   load_result;
  logic [7:0]             win_total;
  logic [7:0]             isi_sample;
  logic [7:0]             isi_next;

  always_comb begin
    spike_event = spike & ~spike_d & enable;
    terminal    = enable & (win_cnt == '1);
    win_total   = (spike_event && (spk_cnt != 8'hFF)) ? spk_cnt + 8'd1 : spk_cnt;
    isi_sample  = (isi_cnt == 8'hFF) ? 8'hFF : isi_cnt + 8'd1;
    // Same-cycle ISI update is forwarded so a terminal-cycle event reaches the result.
    isi_next    = (spike_event && seen_first) ? isi_sample : last_isi;
    load_result = terminal & (~out_valid | out_ready);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      spike_d    <= 1'b0;
      win_cnt    <= '0;
      spk_cnt    <= '0;
      isi_cnt    <= '0;
      last_isi   <= '0;
      seen_first <= 1'b0;
    end else begin
      spike_d <= spike;
      if (enable) begin
        win_cnt <= win_cnt + 1'b1;
      end
      // Terminal-cycle event belongs to the closing window only.
      spk_cnt <= terminal ? '0 : win_total;
      if (spike_event) begin
        isi_cnt <= '0;
      end else if (enable && (isi_cnt != 8'hFF)) begin
        isi_cnt <= isi_cnt + 8'd1;
      end
      last_isi <= isi_next;
      if (spike_event) begin
        seen_first <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rate      <= '0;
      isi       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (load_result) begin
      rate      <= win_total;
      isi       <= isi_next;
      out_valid <= 1'b1;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (terminal) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: a 16-cycle-window instance for most scenarios
// and a 512-cycle-window instance for rate/ISI saturation.
module tb_spike_rate_decoder;

  typedef struct packed {
    logic [7:0] rate;
    logic [7:0] isi;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset4_n, spike4, enable4, ready4;
  logic [7:0] rate4, isi4;
  logic       out_valid4, overrun4;

  logic       reset9_n, spike9, enable9, ready9;
  logic [7:0] rate9, isi9;
  logic       out_valid9, overrun9;

  exp_t q4[$];
  exp_t q9[$];
  exp_t e4, e9;

  int checks = 0;
  int errors = 0;

  spike_rate_decoder #(.WINDOW_LOG2(4)) u4 (
    .clk(clk), .reset_n(reset4_n), .spike(spike4), .enable(enable4), .out_ready(ready4),
    .rate(rate4), .isi(isi4), .out_valid(out_valid4), .overrun(overrun4)
  );

  spike_rate_decoder #(.WINDOW_LOG2(9)) u9 (
    .clk(clk), .reset_n(reset9_n), .spike(spike9), .enable(enable9), .out_ready(ready9),
    .rate(rate9), .isi(isi9), .out_valid(out_valid9), .overrun(overrun9)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step4(input logic s, input logic en, input logic rdy);
    spike4  = s;
    enable4 = en;
    ready4  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic step9(input logic s, input logic en, input logic rdy);
    spike9  = s;
    enable9 = en;
    ready9  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset4();
    reset4_n = 1'b0;
    step4(1'b0, 1'b0, 1'b0);
    reset4_n = 1'b1;
  endtask

  // Monitors: a result is consumed whenever valid and ready meet at the next edge.
  always @(negedge clk) begin
    if (reset4_n && out_valid4 && ready4) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u4_unexpected: got rate=%0d isi=%0d, expected no result", rate4, isi4);
      end else begin
        e4 = q4.pop_front();
        chk("u4_rate", int'(rate4), int'(e4.rate));
        chk("u4_isi", int'(isi4), int'(e4.isi));
      end
    end
  end

  always @(negedge clk) begin
    if (reset9_n && out_valid9 && ready9) begin
      if (q9.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u9_unexpected: got rate=%0d isi=%0d, expected no result", rate9, isi9);
      end else begin
        e9 = q9.pop_front();
        chk("u9_rate", int'(rate9), int'(e9.rate));
        chk("u9_isi", int'(isi9), int'(e9.isi));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    spike4 = 0; enable4 = 0; ready4 = 0; reset4_n = 0;
    spike9 = 0; enable9 = 0; ready9 = 0; reset9_n = 0;
    step4(0, 0, 0);
    step4(0, 0, 0);
    reset4_n = 1'b1;
    reset9_n = 1'b1;
    chk("reset_rate", int'(rate4), 0);
    chk("reset_isi", int'(isi4), 0);
    chk("reset_valid", int'(out_valid4), 0);
    chk("reset_overrun", int'(overrun4), 0);
    chk("reset9_valid", int'(out_valid9), 0);

    // Periodic train: pulse every 4 cycles -> rate 4, isi 4 after 16 cycles.
    do_reset4();
    q4.push_back('{rate: 8'd4, isi: 8'd4});
    for (int k = 0; k < 16; k++) begin
      step4(k % 4 == 0, 1, 1);
      if (k == 14) chk("t1_valid_early", int'(out_valid4), 0);
      if (k == 15) chk("t1_valid_on_time", int'(out_valid4), 1);
    end
    step4(0, 0, 1);

    // Held level counts once; second pulse 20 cycles later -> isi 20.
    do_reset4();
    q4.push_back('{rate: 8'd1, isi: 8'd0});
    q4.push_back('{rate: 8'd1, isi: 8'd20});
    for (int k = 0; k < 32; k++) begin
      step4((k < 10) || (k == 20), 1, 1);
    end
    step4(0, 0, 1);

    // Backpressure: first result held, second dropped, overrun sticky.
    do_reset4();
    q4.push_back('{rate: 8'd2, isi: 8'd4});
    for (int k = 0; k < 32; k++) begin
      step4((k == 2) || (k == 6) || (k == 18) || (k == 20) || (k == 22), 1, 0);
      if (k >= 15) begin
        chk("t3_hold_valid", int'(out_valid4), 1);
        chk("t3_hold_rate", int'(rate4), 2);
        chk("t3_hold_isi", int'(isi4), 4);
      end
      if (k == 30) chk("t3_overrun_before", int'(overrun4), 0);
    end
    chk("t3_overrun_set", int'(overrun4), 1);
    step4(0, 1, 1);
    chk("t3_valid_drop", int'(out_valid4), 0);
    chk("t3_overrun_sticky", int'(overrun4), 1);
    step4(0, 1, 0);
    chk("t3_overrun_sticky2", int'(overrun4), 1);

    // Enable gating: 10 disabled cycles with pulses delay the result by 10 cycles.
    do_reset4();
    q4.push_back('{rate: 8'd2, isi: 8'd7});
    for (int k = 0; k < 30; k++) begin
      if (k < 5)       step4(k == 1, 1, 1);
      else if (k < 15) step4(k % 2 == 0, 0, 1);
      else             step4((k == 18) || (k == 27), 1, 1);
      if (k == 24) chk("t4_valid_early", int'(out_valid4), 0);
      if (k == 25) chk("t4_valid_delayed", int'(out_valid4), 1);
    end
    do_reset4();
    chk("t4_reset_rate", int'(rate4), 0);
    chk("t4_reset_isi", int'(isi4), 0);
    chk("t4_reset_valid", int'(out_valid4), 0);
    chk("t4_reset_overrun", int'(overrun4), 0);
    q4.push_back('{rate: 8'd0, isi: 8'd0});
    for (int k = 0; k < 16; k++) begin
      step4(0, 1, 1);
      if (k == 14) chk("t4_post_reset_early", int'(out_valid4), 0);
      if (k == 15) chk("t4_post_reset_on_time", int'(out_valid4), 1);
    end
    step4(0, 0, 1);

    // Terminal-cycle spike coinciding with acceptance of the previous result.
    do_reset4();
    q4.push_back('{rate: 8'd1, isi: 8'd0});
    q4.push_back('{rate: 8'd2, isi: 8'd11});
    for (int k = 0; k < 32; k++) begin
      step4((k == 3) || (k == 20) || (k == 31), 1, k == 31);
    end
    chk("t6_valid_stays", int'(out_valid4), 1);
    chk("t6_no_overrun", int'(overrun4), 0);
    step4(0, 1, 1);
    chk("t6_valid_drop", int'(out_valid4), 0);
    step4(0, 0, 1);

    // Saturation on the 512-cycle window: 256 edges -> 255; 300 idle cycles -> isi 255.
    q9.push_back('{rate: 8'd255, isi: 8'd2});
    q9.push_back('{rate: 8'd1, isi: 8'd255});
    for (int k = 0; k < 1024; k++) begin
      step9(((k < 512) && (k % 2 == 0)) || (k == 810), 1, 1);
      if (k == 510) chk("t5_valid_early", int'(out_valid9), 0);
      if (k == 511) chk("t5_valid_on_time", int'(out_valid9), 1);
    end
    step9(0, 0, 1);
    step9(0, 0, 1);

    chk("q4_drained", q4.size(), 0);
    chk("q9_drained", q9.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
